// File: rtl/serial_pkg.sv
//============================================================================
// Module   : serial_pkg
// Brief    : Shared state type and bit-ordering helper for the serial link.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package serial_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } serial_state_t;

    // Maps the position within a word to the shifter bit carried on the line.
    function automatic int unsigned bit_index(
        input int unsigned ctr,
        input int unsigned bits,
        input logic        lowbit_first
    );
        return lowbit_first ? ctr : (bits - 32'd1 - ctr);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_duplex_target_if.sv
//============================================================================
// Module   : serial_duplex_target_if
// Brief    : Parallel word exchange between the serial target and the fabric.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface serial_duplex_target_if #(
    parameter int BITS = 8
);
    logic [BITS-1:0] in_tx_data;
    logic            in_tx_valid;
    logic            out_tx_ready;
    logic [BITS-1:0] out_rx_data;
    logic            out_rx_valid;

    modport master (
        output in_tx_data,
        output in_tx_valid,
        input  out_tx_ready,
        input  out_rx_data,
        input  out_rx_valid
    );

    modport slave (
        input  in_tx_data,
        input  in_tx_valid,
        output out_tx_ready,
        output out_rx_data,
        output out_rx_valid
    );
endinterface

`default_nettype wire

// File: rtl/serial_duplex_target.sv
//============================================================================
// Module   : serial_duplex_target
// Brief    : Full-duplex serial target clocked by the initiator's serial clock.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module serial_duplex_target
    import serial_pkg::*;
#(
    parameter int              BITS                 = 8,
    parameter logic            LOWBIT_FIRST         = 1'b1,
    parameter logic            SERIAL_DATA_INACTIVE = 1'b1,
    parameter logic [BITS-1:0] TX_IDLE_WORD         = '1
) (
    input  logic                 serial_clk,
    input  logic                 in_rst,
    input  logic                 in_enable,
    input  logic                 in_serial,
    output logic                 out_serial,
    output logic                 out_word_next,
    output logic                 out_underrun,
    input  logic                 in_clear_status,
    serial_duplex_target_if.slave bus
);

    localparam int                 c_CTR_W = $clog2(BITS) + 1;
    localparam int                 c_IDX_W = $clog2(BITS);
    localparam logic [c_CTR_W-1:0] c_LAST  = c_CTR_W'(BITS - 1);

    serial_state_t      r_state;
    serial_state_t      w_state_next;
    logic [c_CTR_W-1:0] r_bit_ctr;
    logic [c_CTR_W-1:0] w_bit_ctr_next;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_last;
    logic               w_load;
    logic               w_shift;
    logic               w_write;

    logic [BITS-1:0]    r_tx_shift;
    logic [BITS-1:0]    r_rx_shift;
    logic [BITS-1:0]    w_rx_word;
    logic [BITS-1:0]    r_hold_data;
    logic               r_hold_full;
    logic [BITS-1:0]    r_rx_data;
    logic               r_rx_valid;
    logic               r_underrun;

    assign w_idx   = c_IDX_W'(bit_index(32'(r_bit_ctr), BITS, LOWBIT_FIRST));
    assign w_last  = (r_state == ST_SHIFT) && (r_bit_ctr == c_LAST);
    assign w_write = bus.in_tx_valid && !r_hold_full;

    always_comb begin
        w_state_next   = r_state;
        w_bit_ctr_next = r_bit_ctr;
        w_load         = 1'b0;
        w_shift        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_bit_ctr_next = '0;
                if (in_enable) begin
                    w_state_next = ST_SHIFT;
                    w_load       = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!in_enable) begin
                    w_state_next   = ST_IDLE;
                    w_bit_ctr_next = '0;
                end else begin
                    w_shift = 1'b1;
                    // Word boundary reloads immediately so words run back to back.
                    if (w_last) begin
                        w_bit_ctr_next = '0;
                        w_load         = 1'b1;
                    end else begin
                        w_bit_ctr_next = r_bit_ctr + c_CTR_W'(1);
                    end
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_bit_ctr_next = '0;
            end
        endcase
    end

    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state   <= ST_IDLE;
            r_bit_ctr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_ctr <= w_bit_ctr_next;
        end
    end

    // Completed word must include the bit arriving on this very edge.
    always_comb begin
        w_rx_word        = r_rx_shift;
        w_rx_word[w_idx] = in_serial;
    end

    always_ff @(posedge serial_clk or posedge in_rst) begin
        if (in_rst) begin
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_rx_valid <= w_shift && w_last;
            if (w_shift) begin
                r_rx_shift <= w_rx_word;
            end
            if (w_shift && w_last) begin
                r_rx_data <= w_rx_word;
            end
            if (w_load) begin
                r_tx_shift <= r_hold_full ? r_hold_data : TX_IDLE_WORD;
            end
            // A load of a full register wins over a same-edge write attempt.
            if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (w_write) begin
                r_hold_full <= 1'b1;
            end
            if (w_write) begin
                r_hold_data <= bus.in_tx_data;
            end
            if (in_clear_status) begin
                r_underrun <= 1'b0;
            end else if (w_load && !r_hold_full) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign out_serial       = (r_state == ST_SHIFT) ? r_tx_shift[w_idx] : SERIAL_DATA_INACTIVE;
    assign out_word_next    = w_last;
    assign out_underrun     = r_underrun;
    assign bus.out_tx_ready = !r_hold_full;
    assign bus.out_rx_data  = r_rx_data;
    assign bus.out_rx_valid = r_rx_valid;

endmodule

`default_nettype wire

// File: tb/tb_serial_duplex_target.sv
//============================================================================
// Module   : tb_serial_duplex_target
// Brief    : Self-checking bench; LSB-first and MSB-first targets share stimulus.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_serial_duplex_target;
    import serial_pkg::*;

    localparam int         BITS   = 8;
    localparam logic [7:0] IDLE_W = 8'hFF;

    logic       serial_clk;
    logic       in_rst, in_enable, in_serial, in_clear_status, tx_valid;
    logic [7:0] tx_data;

    logic       ser [2];
    logic       wn  [2];
    logic       ur  [2];
    logic       rdy [2];
    logic [7:0] rxd [2];
    logic       rxv [2];

    int n_checks = 0;
    int n_fail   = 0;

    serial_duplex_target_if #(.BITS(BITS)) bus_l ();
    serial_duplex_target_if #(.BITS(BITS)) bus_m ();

    assign bus_l.in_tx_data  = tx_data;
    assign bus_l.in_tx_valid = tx_valid;
    assign bus_m.in_tx_data  = tx_data;
    assign bus_m.in_tx_valid = tx_valid;
    assign rdy[0] = bus_l.out_tx_ready;
    assign rxd[0] = bus_l.out_rx_data;
    assign rxv[0] = bus_l.out_rx_valid;
    assign rdy[1] = bus_m.out_tx_ready;
    assign rxd[1] = bus_m.out_rx_data;
    assign rxv[1] = bus_m.out_rx_valid;

    serial_duplex_target #(
        .BITS(BITS), .LOWBIT_FIRST(1'b1), .SERIAL_DATA_INACTIVE(1'b1), .TX_IDLE_WORD(IDLE_W)
    ) dut_l (
        .serial_clk(serial_clk), .in_rst(in_rst), .in_enable(in_enable), .in_serial(in_serial),
        .out_serial(ser[0]), .out_word_next(wn[0]), .out_underrun(ur[0]),
        .in_clear_status(in_clear_status), .bus(bus_l.slave)
    );

    serial_duplex_target #(
        .BITS(BITS), .LOWBIT_FIRST(1'b0), .SERIAL_DATA_INACTIVE(1'b1), .TX_IDLE_WORD(IDLE_W)
    ) dut_m (
        .serial_clk(serial_clk), .in_rst(in_rst), .in_enable(in_enable), .in_serial(in_serial),
        .out_serial(ser[1]), .out_word_next(wn[1]), .out_underrun(ur[1]),
        .in_clear_status(in_clear_status), .bus(bus_m.slave)
    );

    initial serial_clk = 1'b0;
    always #5 serial_clk = ~serial_clk;

    // Stream-level reference: position in the current word, word on the line,
    // a one-deep queue of accepted writes, and words assembled in arrival order.
    bit         m_frame;
    int         m_pos;
    logic [7:0] m_cur;
    logic [7:0] m_pending[$];
    logic [7:0] m_stream;
    logic [7:0] m_rx[2];
    bit         m_strobe;
    bit         m_under;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic model_reset();
        m_frame = 0; m_pos = 0; m_cur = '0; m_pending.delete();
        m_stream = '0; m_rx[0] = '0; m_rx[1] = '0; m_strobe = 0; m_under = 0;
    endtask

    task automatic model_edge();
        bit shifting, boundary, accept;
        if (in_rst) begin
            model_reset();
            return;
        end
        shifting = m_frame && in_enable;
        boundary = in_enable && (!m_frame || (m_pos == BITS-1));
        accept   = tx_valid && (m_pending.size() == 0);
        m_strobe = 0;
        if (shifting) begin
            m_stream[m_pos] = in_serial;
            if (m_pos == BITS-1) begin
                m_rx[0]  = m_stream;
                m_rx[1]  = rev8(m_stream);
                m_strobe = 1;
            end
        end
        if (boundary) begin
            if (m_pending.size() != 0) begin
                m_cur = m_pending.pop_front();
            end else begin
                m_cur   = IDLE_W;
                m_under = 1;
            end
            m_pos   = 0;
            m_frame = 1;
        end else if (shifting) begin
            m_pos++;
        end else begin
            m_frame = 0;
        end
        if (in_clear_status) m_under = 0;
        if (accept) m_pending.push_back(tx_data);
    endtask

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [dut%0d]: got 0x%0h, expected 0x%0h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            int   p;
            logic e_ser;
            p     = (d == 0) ? m_pos : (BITS - 1 - m_pos);
            e_ser = m_frame ? m_cur[p] : 1'b1;
            check("out_serial",    d, 32'(ser[d]), 32'(e_ser));
            check("out_word_next", d, 32'(wn[d]),  32'(m_frame && (m_pos == BITS-1)));
            check("out_tx_ready",  d, 32'(rdy[d]), 32'(m_pending.size() == 0));
            check("out_rx_valid",  d, 32'(rxv[d]), 32'(m_strobe));
            check("out_rx_data",   d, 32'(rxd[d]), 32'(m_rx[d]));
            check("out_underrun",  d, 32'(ur[d]),  32'(m_under));
        end
    endtask

    task automatic step();
        @(posedge serial_clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] feed;   // bit k is the k-th bit placed on in_serial
        logic [7:0] exp_l;
        logic [7:0] exp_m;
    } vec_t;

    vec_t vecs[5];

    task automatic table_row(input vec_t v);
        logic [7:0] cap_l, cap_m;
        tx_valid = 1; tx_data = v.tx; step(); tx_valid = 0;
        in_enable = 1; step();
        for (int k = 0; k < BITS; k++) begin
            in_serial = v.feed[k];
            cap_l[k] = ser[0];
            cap_m[BITS-1-k] = ser[1];
            tx_valid = (k == 0); tx_data = 8'h00;
            step();
        end
        tx_valid = 0;
        check("tbl_tx_word", 0, 32'(cap_l), 32'(v.tx));
        check("tbl_tx_word", 1, 32'(cap_m), 32'(v.tx));
        check("tbl_rx_valid", 0, 32'(rxv[0]), 32'd1);
        check("tbl_rx_data", 0, 32'(rxd[0]), 32'(v.exp_l));
        check("tbl_rx_data", 1, 32'(rxd[1]), 32'(v.exp_m));
        check("tbl_underrun", 0, 32'(ur[0]), 32'd0);
        in_enable = 0; step();
        check("tbl_rx_valid_1cyc", 0, 32'(rxv[0]), 32'd0);
        check("tbl_idle_level", 1, 32'(ser[1]), 32'd1);
    endtask

    initial begin
        logic [7:0] wr[4];
        logic [7:0] caps[3];
        logic [7:0] cap;
        logic [31:0] mask;
        int nw, strobes;

        in_rst = 1; in_enable = 0; in_serial = 0; in_clear_status = 0; tx_valid = 0; tx_data = '0;
        model_reset();
        #2;
        check_outputs();
        check("rst_serial", 0, 32'(ser[0]), 32'd1);
        check("rst_ready", 0, 32'(rdy[0]), 32'd1);
        check("rst_rx_data", 0, 32'(rxd[0]), 32'd0);
        step(); step();
        in_rst = 0; step();

        vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 8'h3C};
        vecs[1] = '{8'h81, 8'hF0, 8'hF0, 8'h0F};
        vecs[2] = '{8'h5A, 8'h01, 8'h01, 8'h80};
        vecs[3] = '{8'h00, 8'hC8, 8'hC8, 8'h13};
        vecs[4] = '{8'hFE, 8'h6D, 8'h6D, 8'hB6};
        for (int i = 0; i < 5; i++) table_row(vecs[i]);

        // Three back-to-back words, refilling whenever the holding register empties.
        wr[0] = 8'h11; wr[1] = 8'h22; wr[2] = 8'h33; wr[3] = 8'h00;
        tx_valid = 1; tx_data = wr[0]; step(); tx_valid = 0; nw = 1;
        in_enable = 1; step();
        mask = '0; strobes = 0;
        for (int k = 0; k < 3*BITS; k++) begin
            in_serial = 1'($urandom);
            caps[k/BITS][k%BITS] = ser[0];
            if (wn[0]) mask[k] = 1'b1;
            if (m_pending.size() == 0 && nw < 4) begin
                tx_valid = 1; tx_data = wr[nw]; nw++;
            end else begin
                tx_valid = 0;
            end
            step();
            if (rxv[0]) strobes++;
        end
        tx_valid = 0;
        check("b2b_word_next_pos", 0, mask, 32'h0080_8080);
        check("b2b_rx_strobes", 0, 32'(strobes), 32'd3);
        check("b2b_word0", 0, 32'(caps[0]), 32'h11);
        check("b2b_word1", 0, 32'(caps[1]), 32'h22);
        check("b2b_word2", 0, 32'(caps[2]), 32'h33);
        check("b2b_underrun", 0, 32'(ur[0]), 32'd0);
        in_enable = 0; step();

        // Underrun and its clear, including clear on the underrun edge.
        in_enable = 1; step();
        check("udr_set", 0, 32'(ur[0]), 32'd1);
        check("udr_set", 1, 32'(ur[1]), 32'd1);
        for (int k = 0; k < BITS; k++) begin
            cap[k] = ser[0];
            in_serial = 1'($urandom);
            step();
        end
        check("udr_idle_word", 0, 32'(cap), 32'hFF);
        in_enable = 0; step();
        in_clear_status = 1; step(); in_clear_status = 0;
        check("udr_cleared", 0, 32'(ur[0]), 32'd0);
        in_clear_status = 1; in_enable = 1; step(); in_clear_status = 0;
        check("udr_clear_prio", 0, 32'(ur[0]), 32'd0);
        step(); step();
        in_enable = 0; step();
        check("udr_abort_no_set", 0, 32'(ur[0]), 32'd0);

        // Abort after bit 4; the queued word must start the next frame at bit 0.
        tx_valid = 1; tx_data = 8'h3A; step(); tx_valid = 0;
        in_enable = 1; step();
        for (int k = 0; k < 5; k++) begin
            in_serial = 1'($urandom);
            tx_valid = (k == 0); tx_data = 8'h6B;
            step();
        end
        tx_valid = 0; in_enable = 0; step();
        check("abort_idle_level", 0, 32'(ser[0]), 32'd1);
        check("abort_no_strobe", 0, 32'(rxv[0]), 32'd0);
        check("abort_hold_kept", 0, 32'(rdy[0]), 32'd0);
        step();
        in_enable = 1; step();
        for (int k = 0; k < BITS; k++) begin
            cap[k] = ser[0];
            in_serial = k[0] ^ k[2];
            step();
        end
        check("abort_restart_word", 0, 32'(cap), 32'h6B);
        check("abort_restart_rx", 0, 32'(rxd[0]), 32'h5A);
        in_enable = 0; step();

        // Asynchronous reset at bit 5.
        tx_valid = 1; tx_data = 8'h77; step(); tx_valid = 0;
        in_enable = 1; step();
        for (int k = 0; k < 5; k++) begin
            in_serial = 1'($urandom);
            step();
        end
        #2; in_rst = 1; #1;
        model_reset();
        check_outputs();
        check("rst_mid_serial", 0, 32'(ser[0]), 32'd1);
        check("rst_mid_rx_data", 0, 32'(rxd[0]), 32'd0);
        check("rst_mid_word_next", 1, 32'(wn[1]), 32'd0);
        in_enable = 0; step(); step();
        in_rst = 0; step();
        check("rst_mid_no_strobe", 0, 32'(rxv[0]), 32'd0);

        // Randomised traffic against the stream model.
        for (int i = 0; i < 2000; i++) begin
            in_enable       = ($urandom_range(0, 9) != 0);
            in_serial       = 1'($urandom);
            tx_valid        = 1'($urandom);
            tx_data         = 8'($urandom);
            in_clear_status = ($urandom_range(0, 15) == 0);
            in_rst          = ($urandom_range(0, 299) == 0);
            step();
        end
        in_rst = 0; in_enable = 0; tx_valid = 0; in_clear_status = 0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
